// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: write-back FSM states, one-hot field bit indices
// for load alignment and write-data source select, and the default link offset.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } wb_state_e;

  localparam int ALIGN_W = 7;
  localparam int AL_LW   = 6;
  localparam int AL_LB   = 5;
  localparam int AL_LBU  = 4;
  localparam int AL_LH   = 3;
  localparam int AL_LHU  = 2;
  localparam int AL_LWL  = 1;
  localparam int AL_LWR  = 0;

  // Bit 0 selects the ALU result, which is also the fallback when no other bit is set.
  localparam int SRC_W    = 3;
  localparam int SRC_LINK = 2;
  localparam int SRC_LOAD = 1;

  localparam int LINK_OFFSET_DEF = 8;

endpackage

// File: rtl/wb_stage_if.sv
// MA-to-WB handshake bundle: retiring instruction fields driven by MA,
// plus WB_enable flowing back to tell MA the stage can accept this cycle.
interface wb_stage_if;
  import cpu_pkg::*;

  logic               MA_ready;
  logic               WB_enable;
  logic [31:0]        rf_B_in;
  logic [4:0]         rf_waddr_in;
  logic [SRC_W-1:0]   rf_wdata_src_in;
  logic               rf_wen_in;
  logic [31:0]        alu_res_in;
  logic               mem_read_in;
  logic [ALIGN_W-1:0] align_load_in;
  logic [31:0]        MA_PC;

  modport master (
    output MA_ready, rf_B_in, rf_waddr_in, rf_wdata_src_in, rf_wen_in,
           alu_res_in, mem_read_in, align_load_in, MA_PC,
    input  WB_enable
  );

  modport slave (
    input  MA_ready, rf_B_in, rf_waddr_in, rf_wdata_src_in, rf_wen_in,
           alu_res_in, mem_read_in, align_load_in, MA_PC,
    output WB_enable
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: extracts/extends the addressed byte or halfword,
// or merges the word with the old rt value for the little-endian lwl/lwr pair.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0]        rdata,
  input  logic [1:0]         off,
  input  logic [ALIGN_W-1:0] align_load,
  input  logic [31:0]        rf_b,
  output logic [31:0]        aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_word;
  logic [31:0] lwr_word;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    lwl_word = rdata;
    lwr_word = rdata;
    // lwl fills rt from the top down, lwr from the bottom up; the rest keeps rt.
    case (off)
      2'd0: begin
        lwl_word = {rdata[7:0], rf_b[23:0]};
        lwr_word = rdata;
      end
      2'd1: begin
        lwl_word = {rdata[15:0], rf_b[15:0]};
        lwr_word = {rf_b[31:24], rdata[31:8]};
      end
      2'd2: begin
        lwl_word = {rdata[23:0], rf_b[7:0]};
        lwr_word = {rf_b[31:16], rdata[31:16]};
      end
      2'd3: begin
        lwl_word = rdata;
        lwr_word = {rf_b[31:8], rdata[31:24]};
      end
      default: begin
        lwl_word = rdata;
        lwr_word = rdata;
      end
    endcase

    aligned = rdata;
    if (align_load[AL_LB])       aligned = {{24{byte_sel[7]}}, byte_sel};
    else if (align_load[AL_LBU]) aligned = {24'd0, byte_sel};
    else if (align_load[AL_LH])  aligned = {{16{half_sel[15]}}, half_sel};
    else if (align_load[AL_LHU]) aligned = {16'd0, half_sel};
    else if (align_load[AL_LWL]) aligned = lwl_word;
    else if (align_load[AL_LWR]) aligned = lwr_word;
    else if (align_load[AL_LW])  aligned = rdata;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches the retiring instruction, waits for load data, aligns it
// and drives the register-file write port. Define WB_DEBUG_TRACE_EN for debug_wb_* trace outputs.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              empty,
  wb_stage_if.slave         ma,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] WB_PC,
  output logic              valid_out,
  output logic              wb_stall_out
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  wb_state_e          state_q, state_d;
  logic               valid_q, valid_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               wen_q, wen_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [ALIGN_W-1:0] align_q, align_d;
  logic [DATA_W-1:0]  rf_b_q, rf_b_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rf_wen_q, rf_wen_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  aligned_d;
  logic               mem_wait;
  logic               wb_enable;
  logic               comming;

  assign mem_wait     = (state_q == WAIT) || (state_q == DRAIN);
  assign wb_enable    = (state_q == IDLE) || ((state_q == WRITE) && !mem_wait);
  assign comming      = wb_enable && ma.MA_ready;
  assign ma.WB_enable = wb_enable;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    waddr_d = waddr_q;
    src_d   = src_q;
    wen_d   = wen_q;
    alu_d   = alu_q;
    align_d = align_q;
    rf_b_d  = rf_b_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, WRITE: begin
        if (empty) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (comming) begin
          valid_d = 1'b1;
          waddr_d = ma.rf_waddr_in;
          src_d   = ma.rf_wdata_src_in;
          wen_d   = ma.rf_wen_in;
          alu_d   = ma.alu_res_in;
          align_d = ma.align_load_in;
          rf_b_d  = ma.rf_B_in;
          pc_d    = ma.MA_PC;
          state_d = ma.mem_read_in ? WAIT : WRITE;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      // A flush while a load is owed must still absorb that response before accepting again.
      WAIT: begin
        if (mem_data_ok) begin
          rdata_d = mem_rdata;
          if (empty) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = WRITE;
          end
        end else if (empty) begin
          state_d = DRAIN;
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (mem_data_ok) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  load_align u_load_align (
    .rdata      (rdata_d),
    .off        (alu_d[1:0]),
    .align_load (align_d),
    .rf_b       (rf_b_d),
    .aligned    (aligned_d)
  );

  // Write-port outputs are registered from next-state values so they line up with the state.
  always_comb begin
    rf_wen_d = valid_d && wen_d && (state_d == WRITE);
    if (src_d[SRC_LOAD])      wdata_d = aligned_d;
    else if (src_d[SRC_LINK]) wdata_d = pc_d + DATA_W'(LINK_OFFSET);
    else                      wdata_d = alu_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      waddr_q  <= '0;
      src_q    <= '0;
      wen_q    <= 1'b0;
      alu_q    <= '0;
      align_q  <= '0;
      rf_b_q   <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      rf_wen_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      waddr_q  <= waddr_d;
      src_q    <= src_d;
      wen_q    <= wen_d;
      alu_q    <= alu_d;
      align_q  <= align_d;
      rf_b_q   <= rf_b_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
      rf_wen_q <= rf_wen_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign WB_PC        = pc_q;
  assign valid_out    = valid_q;
  assign wb_stall_out = (state_q == WAIT);

`ifdef WB_DEBUG_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_pc       <= 32'(pc_d);
      debug_wb_rf_wen   <= {4{rf_wen_d}};
      debug_wb_rf_wnum  <= waddr_d;
      debug_wb_rf_wdata <= 32'(wdata_d);
    end
  end
`endif

  // Load responses are only legal while a load is owed.
  mem_ok_protocol_a: assert property (@(posedge clk) disable iff (!rst_n)
    mem_data_ok |-> mem_wait);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected register writes,
// a negedge monitor pops and compares whenever rf_wen is seen.
module tb_wb_stage;

  localparam logic [6:0] A_LW  = 7'b1000000;
  localparam logic [6:0] A_LB  = 7'b0100000;
  localparam logic [6:0] A_LBU = 7'b0010000;
  localparam logic [6:0] A_LH  = 7'b0001000;
  localparam logic [6:0] A_LHU = 7'b0000100;
  localparam logic [6:0] A_LWL = 7'b0000010;
  localparam logic [6:0] A_LWR = 7'b0000001;
  localparam logic [6:0] A_NON = 7'b0000000;
  localparam logic [2:0] S_ALU  = 3'b001;
  localparam logic [2:0] S_LOAD = 3'b010;
  localparam logic [2:0] S_LINK = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        empty;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] WB_PC;
  logic        valid_out;
  logic        wb_stall_out;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_stage_if ma_if ();

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .empty        (empty),
    .ma           (ma_if),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .WB_PC        (WB_PC),
    .valid_out    (valid_out),
    .wb_stall_out (wb_stall_out)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_write: no write seen for r%0d, expected 0x%08h in cycle %0d (now %0d)",
                 e.waddr, e.wdata, e.cyc, cyc);
      end
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: r%0d <= 0x%08h in cycle %0d, expected no write",
                   rf_waddr, rf_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("write_addr", 32'(rf_waddr), 32'(e.waddr));
          checkOutput("write_data", rf_wdata, e.wdata);
          checkOutput("write_pc", WB_PC, e.pc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveFields(input logic [4:0] waddr, input logic [2:0] src, input logic wen,
                             input logic [31:0] alu, input logic rd, input logic [6:0] align,
                             input logic [31:0] rfb, input logic [31:0] pc);
    ma_if.rf_waddr_in     = waddr;
    ma_if.rf_wdata_src_in = src;
    ma_if.rf_wen_in       = wen;
    ma_if.alu_res_in      = alu;
    ma_if.mem_read_in     = rd;
    ma_if.align_load_in   = align;
    ma_if.rf_B_in         = rfb;
    ma_if.MA_PC           = pc;
    ma_if.MA_ready        = 1'b1;
  endtask

  // Offers one instruction for one cycle; non-loads that write are expected next cycle.
  task automatic applyStimulus(input logic [4:0] waddr, input logic [2:0] src, input logic wen,
                               input logic [31:0] alu, input logic rd, input logic [6:0] align,
                               input logic [31:0] rfb, input logic [31:0] pc,
                               input logic [31:0] exp_wdata);
    exp_t e;
    driveFields(waddr, src, wen, alu, rd, align, rfb, pc);
    checkOutput("accept_enable", 32'(ma_if.WB_enable), 32'd1);
    if (rd) begin
      ld_waddr = waddr;
      ld_pc    = pc;
    end else if (wen) begin
      e.waddr = waddr;
      e.wdata = exp_wdata;
      e.cyc   = cyc + 1;
      e.pc    = pc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ma_if.MA_ready = 1'b0;
  endtask

  task automatic giveData(input logic [31:0] rdata, input logic [31:0] exp_wdata, input logic do_push);
    exp_t e;
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    if (do_push) begin
      e.waddr = ld_waddr;
      e.wdata = exp_wdata;
      e.cyc   = cyc + 1;
      e.pc    = ld_pc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    empty       = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    ld_waddr    = '0;
    ld_pc       = '0;
    driveFields(5'd0, 3'd0, 1'b0, 32'd0, 1'b0, A_NON, 32'd0, 32'd0);
    ma_if.MA_ready = 1'b0;
    #2;
    checkOutput("rst_rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
    checkOutput("rst_wb_pc", WB_PC, 32'd0);
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_stall", 32'(wb_stall_out), 32'd0);
    checkOutput("rst_enable", 32'(ma_if.WB_enable), 32'd1);
    idle(3);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] addu, non-writing store, r0 write, jal");
    applyStimulus(5'd3, S_ALU, 1'b1, 32'h0000_1234, 1'b0, A_NON, 32'd0, 32'h0000_0040, 32'h0000_1234);
    checkOutput("write_valid", 32'(valid_out), 32'd1);
    idle(2);
    applyStimulus(5'd7, S_ALU, 1'b0, 32'h0000_0099, 1'b0, A_NON, 32'd0, 32'h0000_0044, 32'd0);
    applyStimulus(5'd0, S_ALU, 1'b1, 32'h0000_0777, 1'b0, A_NON, 32'd0, 32'h0000_0048, 32'h0000_0777);
    applyStimulus(5'd31, S_LINK, 1'b1, 32'h0000_DEAD, 1'b0, A_NON, 32'd0, 32'h0000_1000, 32'h0000_1008);
    idle(2);

    $display("[TB] lb with 3-cycle response, then aligned loads");
    applyStimulus(5'd4, S_LOAD, 1'b1, 32'h0000_0103, 1'b1, A_LB, 32'd0, 32'h0000_0100, 32'd0);
    checkOutput("wait_stall", 32'(wb_stall_out), 32'd1);
    checkOutput("wait_enable", 32'(ma_if.WB_enable), 32'd0);
    checkOutput("wait_valid", 32'(valid_out), 32'd1);
    idle(2);
    giveData(32'h80FF_FFFF, 32'hFFFF_FF80, 1'b1);
    applyStimulus(5'd4, S_LOAD, 1'b1, 32'h0000_0103, 1'b1, A_LBU, 32'd0, 32'h0000_0104, 32'd0);
    idle(2);
    giveData(32'h80FF_FFFF, 32'h0000_0080, 1'b1);
    applyStimulus(5'd9, S_LOAD, 1'b1, 32'h0000_0201, 1'b1, A_LWL, 32'h1122_3344, 32'h0000_0108, 32'd0);
    giveData(32'hAABB_CCDD, 32'hCCDD_3344, 1'b1);
    applyStimulus(5'd9, S_LOAD, 1'b1, 32'h0000_0202, 1'b1, A_LWR, 32'h1122_3344, 32'h0000_010C, 32'd0);
    idle(1);
    giveData(32'hAABB_CCDD, 32'h1122_AABB, 1'b1);
    applyStimulus(5'd11, S_LOAD, 1'b1, 32'h0000_0302, 1'b1, A_LH, 32'd0, 32'h0000_0110, 32'd0);
    giveData(32'h8001_1234, 32'hFFFF_8001, 1'b1);
    applyStimulus(5'd11, S_LOAD, 1'b1, 32'h0000_0300, 1'b1, A_LHU, 32'd0, 32'h0000_0114, 32'd0);
    giveData(32'h1234_F00D, 32'h0000_F00D, 1'b1);
    idle(1);

    $display("[TB] back-to-back issue");
    applyStimulus(5'd8, S_ALU, 1'b1, 32'h0000_0011, 1'b0, A_NON, 32'd0, 32'h0000_0200, 32'h0000_0011);
    applyStimulus(5'd9, S_ALU, 1'b1, 32'h0000_0022, 1'b0, A_NON, 32'd0, 32'h0000_0204, 32'h0000_0022);
    applyStimulus(5'd10, S_LOAD, 1'b1, 32'h0000_0400, 1'b1, A_LW, 32'd0, 32'h0000_0208, 32'd0);
    giveData(32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1);
    idle(2);

    $display("[TB] flush while a load is owed");
    applyStimulus(5'd12, S_LOAD, 1'b1, 32'h0000_0500, 1'b1, A_LW, 32'd0, 32'h0000_0300, 32'd0);
    empty = 1'b1;
    idle(1);
    empty = 1'b0;
    checkOutput("drain_enable", 32'(ma_if.WB_enable), 32'd0);
    checkOutput("drain_valid", 32'(valid_out), 32'd0);
    checkOutput("drain_stall", 32'(wb_stall_out), 32'd0);
    idle(1);
    checkOutput("drain_enable_hold", 32'(ma_if.WB_enable), 32'd0);
    giveData(32'h1234_5678, 32'd0, 1'b0);
    checkOutput("drain_exit_enable", 32'(ma_if.WB_enable), 32'd1);
    idle(2);

    $display("[TB] flush in WRITE drops the incoming instruction");
    applyStimulus(5'd5, S_ALU, 1'b1, 32'h0000_0055, 1'b0, A_NON, 32'd0, 32'h0000_0600, 32'h0000_0055);
    driveFields(5'd6, S_ALU, 1'b1, 32'h0000_0066, 1'b0, A_NON, 32'd0, 32'h0000_0604);
    empty = 1'b1;
    idle(1);
    ma_if.MA_ready = 1'b0;
    empty = 1'b0;
    checkOutput("flush_valid", 32'(valid_out), 32'd0);
    checkOutput("flush_enable", 32'(ma_if.WB_enable), 32'd1);
    idle(2);

    $display("[TB] reset during WAIT");
    applyStimulus(5'd13, S_LOAD, 1'b1, 32'h0000_2000, 1'b1, A_LW, 32'd0, 32'h0000_2000, 32'd0);
    idle(1);
    checkOutput("prereset_stall", 32'(wb_stall_out), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("midrst_rf_wdata", rf_wdata, 32'd0);
    checkOutput("midrst_wb_pc", WB_PC, 32'd0);
    checkOutput("midrst_valid", 32'(valid_out), 32'd0);
    checkOutput("midrst_stall", 32'(wb_stall_out), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    applyStimulus(5'd2, S_ALU, 1'b1, 32'h0000_ABCD, 1'b0, A_NON, 32'd0, 32'h0000_3000, 32'h0000_ABCD);
    idle(3);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
